// File: rtl/lfsr_word_packer.sv
// Packs consecutive Galois LFSR samples into words and streams them through
// a small first-word-fall-through FIFO; each start pulse yields word_count words.
module lfsr_word_packer #(
  parameter int unsigned LFSR_WIDTH = 16,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [15:0]                  word_count,
  input  logic [LFSR_WIDTH-1:0]        lfsr_out,
  output logic                         lfsr_enable,
  output logic [WORD_WIDTH-1:0]        m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned RATIO = WORD_WIDTH / LFSR_WIDTH;
  localparam int unsigned SLW   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned PTRW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVLW  = PTRW + 1;
  localparam int unsigned CNTW  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [SLW-1:0]        slice_q, slice_d;
  logic [WORD_WIDTH-1:0] asm_q, asm_d;
  logic [CNTW-1:0]       remain_q, remain_d;
  logic [PTRW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0]       level_q, level_d;
  logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic push_c;
  logic pop_c;
  logic full_c;
  logic empty_c;

  // Next-state, sample assembly and stream handshake decode
  always_comb begin
    state_d     = state_q;
    slice_d     = slice_q;
    asm_d       = asm_q;
    remain_d    = remain_q;
    push_c      = 1'b0;
    lfsr_enable = 1'b0;
    full_c      = (level_q == LVLW'(FIFO_DEPTH));
    empty_c     = (level_q == '0);
    pop_c       = !empty_c && m_ready;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remain_d = word_count;
          slice_d  = '0;
          state_d  = (word_count == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        // Advancing only when not full keeps every sample and never overflows
        lfsr_enable = !full_c;
        if (!full_c) begin
          for (int unsigned s = 0; s < RATIO; s++) begin
            if (slice_q == SLW'(s)) begin
              asm_d[s*LFSR_WIDTH +: LFSR_WIDTH] = lfsr_out;
            end
          end
          if (slice_q == SLW'(RATIO - 1)) begin
            push_c   = 1'b1;
            slice_d  = '0;
            remain_d = remain_q - CNTW'(1);
            if (remain_q == CNTW'(1)) begin
              state_d = ST_DRAIN;
            end
          end else begin
            slice_d = slice_q + SLW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Leave on the edge that pops the final word so done follows it directly
        if (empty_c || ((level_q == LVLW'(1)) && pop_c)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTRW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTRW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVLW'(1);
      2'b01:   level_d = level_q - LVLW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      slice_q  <= '0;
      asm_q    <= '0;
      remain_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      slice_q  <= slice_d;
      asm_q    <= asm_d;
      remain_q <= remain_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read while occupancy covers them
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= asm_d;
    end
  end

  assign m_valid    = !empty_c;
  assign m_data     = empty_c ? '0 : mem_q[rd_ptr_q];
  assign busy       = (state_q == ST_FILL) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign fifo_level = level_q;

endmodule

// File: tb/tb_lfsr_word_packer.sv
// Self-checking bench for lfsr_word_packer: drives a behavioural Galois LFSR and
// compares the packed word stream with a queue-based reference model.
module tb_lfsr_word_packer;

  localparam int unsigned LW    = 16;
  localparam int unsigned WW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned RATIO = WW / LW;
  localparam logic [LW-1:0] SEED = 16'hACE1;
  localparam logic [LW-1:0] POLY = 16'hB400;

  logic          clk = 1'b0;
  logic          rst;
  logic          lfsr_rst;
  logic          start;
  logic [15:0]   word_count;
  logic [LW-1:0] lfsr_q;
  logic          lfsr_enable;
  logic [WW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic [3:0]    fifo_level;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lfsr_word_packer #(
    .LFSR_WIDTH(LW),
    .WORD_WIDTH(WW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .lfsr_out   (lfsr_q),
    .lfsr_enable(lfsr_enable),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done),
    .fifo_level (fifo_level)
  );

  function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // Upstream LFSR with its own reset
  always @(posedge clk) begin
    if (lfsr_rst) lfsr_q <= SEED;
    else if (lfsr_enable) lfsr_q <= lfsr_step(lfsr_q);
  end

  // Passive monitor sampled mid-cycle
  int mon_cyc = 0, adv_cnt = 0, done_cnt = 0, done_cyc = 0, last_pop_cyc = 0, valid_cnt = 0;
  logic [WW-1:0] got_q[$];
  always @(negedge clk) begin
    mon_cyc <= mon_cyc + 1;
    if (lfsr_enable) adv_cnt <= adv_cnt + 1;
    if (m_valid) valid_cnt <= valid_cnt + 1;
    if (m_valid && m_ready && !rst) begin
      got_q.push_back(m_data);
      last_pop_cyc <= mon_cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= mon_cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    64'(lfsr_enable), 64'(0));
    check({tag, "_valid"}, 64'(m_valid),     64'(0));
    check({tag, "_data"},  64'(m_data),      64'(0));
    check({tag, "_busy"},  64'(busy),        64'(0));
    check({tag, "_done"},  64'(done),        64'(0));
    check({tag, "_level"}, 64'(fifo_level),  64'(0));
  endtask

  // mode 0: always ready, 1: random ready, 2: hold off until full for 10 cycles
  task automatic do_run(input int n, input int mode, input int restart_at, input string name);
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] w;
    logic [LW-1:0] s;
    logic [WW-1:0] prev_data;
    logic          prev_hold;
    int got0, adv0, done0, budget, held, t, max_lvl;
    s = lfsr_q;
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int k = 0; k < int'(RATIO); k++) begin
        w = w | (WW'(s) << (k * int'(LW)));
        s = lfsr_step(s);
      end
      exp_q.push_back(w);
    end
    got0  = got_q.size();
    adv0  = adv_cnt;
    done0 = done_cnt;
    start = 1'b1;
    word_count = 16'(n);
    m_ready = (mode == 0);
    cyc();
    start = 1'b0;
    word_count = 16'($urandom);
    prev_hold = 1'b0;
    prev_data = '0;
    held = 0;
    max_lvl = 0;
    t = 0;
    budget = 40 * n + 200;
    while (done_cnt == done0 && t < budget) begin
      if (prev_hold) begin
        check({name, "_hold_valid"}, 64'(m_valid), 64'(1));
        check({name, "_hold_data"},  64'(m_data),  64'(prev_data));
      end
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom);
        default: begin
          if (fifo_level == 4'(DEPTH) && held < 10) begin
            check({name, "_en_full"}, 64'(lfsr_enable), 64'(0));
            check({name, "_head"},    64'(m_data),      64'(exp_q[0]));
            held++;
          end
          m_ready = (held >= 10);
        end
      endcase
      start = (t == restart_at);
      if (start) word_count = 16'(n + 5);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      cyc();
      t++;
    end
    start = 1'b0;
    check({name, "_timeout"}, 64'(done_cnt != done0), 64'(1));
    repeat (3) cyc();
    check({name, "_done_once"}, 64'(done_cnt - done0), 64'(1));
    check({name, "_busy_end"}, 64'(busy), 64'(0));
    check({name, "_count"}, 64'(got_q.size() - got0), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (got0 + i < got_q.size()) check({name, "_word"}, 64'(got_q[got0 + i]), 64'(exp_q[i]));
    end
    check({name, "_advances"}, 64'(adv_cnt - adv0), 64'(n * int'(RATIO)));
    check({name, "_lfsr_end"}, 64'(lfsr_q), 64'(s));
    if (n > 0) check({name, "_done_after_pop"}, 64'(done_cyc - last_pop_cyc), 64'(1));
    if (mode == 2) check({name, "_max_level"}, 64'(max_lvl), 64'(DEPTH));
  endtask

  initial begin
    int adv0, got0, valid0, t;
    rst = 1'b1;
    lfsr_rst = 1'b1;
    start = 1'b0;
    word_count = '0;
    m_ready = 1'b0;
    repeat (3) cyc();
    check_reset_outputs("reset");
    rst = 1'b0;
    lfsr_rst = 1'b0;
    cyc();

    // Basic run: one word from seed 0xACE1, exact cycle timing
    adv0 = adv_cnt;
    got0 = got_q.size();
    start = 1'b1;
    word_count = 16'd1;
    m_ready = 1'b1;
    cyc();
    start = 1'b0;
    check("basic_busy",   64'(busy),        64'(1));
    check("basic_en",     64'(lfsr_enable), 64'(1));
    check("basic_valid0", 64'(m_valid),     64'(0));
    cyc();
    check("basic_valid1", 64'(m_valid),     64'(0));
    check("basic_en1",    64'(lfsr_enable), 64'(1));
    cyc();
    check("basic_valid2", 64'(m_valid),     64'(1));
    check("basic_data",   64'(m_data),      64'(32'hE270ACE1));
    check("basic_en2",    64'(lfsr_enable), 64'(0));
    cyc();
    check("basic_done",   64'(done),        64'(1));
    check("basic_busy_lo", 64'(busy),       64'(0));
    check("basic_valid3", 64'(m_valid),     64'(0));
    cyc();
    check("basic_done_lo", 64'(done),       64'(0));
    check("basic_adv",    64'(adv_cnt - adv0), 64'(2));
    check("basic_count",  64'(got_q.size() - got0), 64'(1));
    if (got_q.size() > got0) check("basic_word", 64'(got_q[got0]), 64'(32'hE270ACE1));
    check("basic_lfsr",   64'(lfsr_q),      64'(16'h7138));

    // Zero-length run
    adv0 = adv_cnt;
    valid0 = valid_cnt;
    start = 1'b1;
    word_count = 16'd0;
    cyc();
    start = 1'b0;
    check("zero_done",  64'(done),        64'(1));
    check("zero_busy",  64'(busy),        64'(0));
    check("zero_en",    64'(lfsr_enable), 64'(0));
    check("zero_valid", 64'(m_valid),     64'(0));
    cyc();
    check("zero_done_lo", 64'(done), 64'(0));
    cyc();
    check("zero_adv",   64'(adv_cnt - adv0),     64'(0));
    check("zero_vcnt",  64'(valid_cnt - valid0), 64'(0));

    do_run(20, 2, -1, "bp");
    do_run(100, 1, -1, "rand");
    do_run(10, 0, 5, "restart");

    // Reset mid-run with 5 buffered words and a partial word
    m_ready = 1'b0;
    start = 1'b1;
    word_count = 16'd20;
    cyc();
    start = 1'b0;
    t = 0;
    while (fifo_level != 4'd5 && t < 100) begin
      cyc();
      t++;
    end
    check("mid_level", 64'(fifo_level), 64'(5));
    cyc();
    check("mid_partial_level", 64'(fifo_level), 64'(5));
    rst = 1'b1;
    cyc();
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    cyc();
    check_reset_outputs("post_rst");
    do_run(3, 0, -1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
